// File: rtl/param_bus_datapath.sv
// param_bus_datapath: parametrised single-bus datapath with register file, ALU and micro-step sequencer
module param_bus_datapath #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter bit R0_ZERO  = 1'b1,
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int SW = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [AW-1:0]     ra,
    input  logic [AW-1:0]     rb,
    input  logic [AW-1:0]     rc,
    output logic              busy,
    output logic              done,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] bus_data,
    output logic [DATA_W-1:0] hi_data,
    output logic [DATA_W-1:0] lo_data
);
    typedef enum logic [2:0] {IDLE, T_Y, T_Z, T_WB, T_WB2} state_t;
    localparam logic [2:0] OP_MUL = 3'd7;

    state_t              state_q;
    logic [DATA_W-1:0]   rf_q [(1<<AW)];
    logic [DATA_W-1:0]   y_q, zhi_q, zlo_q, hi_q, lo_q;
    logic [2:0]          op_q;
    logic [AW-1:0]       ra_q, rb_q, rc_q;
    logic                done_q;
    logic [DATA_W-1:0]   bus;
    logic [2*DATA_W-1:0] alu;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [DATA_W-1:0]   wdata;

    function automatic logic [DATA_W-1:0] rf_rd(input logic [AW-1:0] a);
        return (32'(a) >= NUM_REGS || (R0_ZERO && a == '0)) ? '0 : rf_q[a];
    endfunction

    // bus source follows the current micro-step; IDLE drives zero
    always_comb begin
        bus = state_q == T_Y   ? rf_rd(rb_q) :
              state_q == T_Z   ? rf_rd(rc_q) :
              state_q == T_WB  ? zlo_q :
              state_q == T_WB2 ? zhi_q : '0;
    end

    // ALU result is double width so MUL keeps its full product; other ops leave the high half zero
    always_comb begin
        alu = '0;
        case (op_q)
            3'd0: alu[DATA_W-1:0] = y_q + bus;
            3'd1: alu[DATA_W-1:0] = y_q - bus;
            3'd2: alu[DATA_W-1:0] = y_q & bus;
            3'd3: alu[DATA_W-1:0] = y_q | bus;
            3'd4: alu[DATA_W-1:0] = y_q ^ bus;
            3'd5: alu[DATA_W-1:0] = y_q << bus[SW-1:0];
            3'd6: alu[DATA_W-1:0] = y_q >> bus[SW-1:0];
            3'd7: alu = {{DATA_W{1'b0}}, y_q} * {{DATA_W{1'b0}}, bus};
            default: alu = '0;
        endcase
    end

    assign we       = (state_q == IDLE && wr_en) || (state_q == T_WB && op_q != OP_MUL);
    assign waddr    = state_q == IDLE ? wr_addr : ra_q;
    assign wdata    = state_q == IDLE ? wr_data : bus;
    assign rd_data  = rf_rd(rd_addr);
    assign bus_data = bus;
    assign hi_data  = hi_q;
    assign lo_data  = lo_q;
    assign busy     = state_q != IDLE;
    assign done     = done_q;

    // register file: external port writes only in IDLE, writeback only in T_WB; R0 and out-of-range slots never change
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < (1<<AW); i++) rf_q[i] <= '0;
        end else if (we && 32'(waddr) < NUM_REGS && !(R0_ZERO && waddr == '0)) begin
            rf_q[waddr] <= wdata;
        end
    end

    // sequencer: IDLE -> T_Y -> T_Z -> T_WB [-> T_WB2] -> IDLE, with done registered off the last writeback
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            y_q     <= '0;
            zhi_q   <= '0;
            zlo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            done_q <= (state_q == T_WB && op_q != OP_MUL) || state_q == T_WB2;
            case (state_q)
                IDLE: if (start) begin
                    op_q    <= op;
                    ra_q    <= ra;
                    rb_q    <= rb;
                    rc_q    <= rc;
                    state_q <= T_Y;
                end
                T_Y: begin
                    y_q     <= bus;
                    state_q <= T_Z;
                end
                T_Z: begin
                    {zhi_q, zlo_q} <= alu;
                    state_q        <= T_WB;
                end
                T_WB: begin
                    if (op_q == OP_MUL) lo_q <= bus;
                    state_q <= op_q == OP_MUL ? T_WB2 : IDLE;
                end
                T_WB2: begin
                    hi_q    <= bus;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
